imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_word_packer.sv | 42 ++++
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared instruction-memory loader definitions: default geometry and the
// loader FSM state encoding used by the loader and anything observing it.
package imem_loader_pkg;

  localparam int I_ADDR_BITS_DEF      = 6;
  localparam int INSTRUCTION_SIZE_DEF = 32;

  // LOAD: collecting bytes, WRITE: one-cycle memory strobe,
  // RUN: program loaded and core released, ERR: program overflowed memory.
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERR   = 2'd3
  } ld_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer. The first accepted byte lands in [7:0],
// the next in [15:8], and so on. Clearing zeroes the whole word, so a word
// that ends early keeps its unfilled upper bytes at zero.
module imem_word_packer #(
  parameter int INSTRUCTION_SIZE = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        byte_en,
  input  logic [7:0]                  byte_data,
  output logic [INSTRUCTION_SIZE-1:0] word,
  output logic                        last_lane
);

  localparam int BYTES  = INSTRUCTION_SIZE / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [LANE_W-1:0] LANE_ONE = LANE_W'(1);
  localparam logic [LANE_W-1:0] LANE_TOP = LANE_W'(BYTES - 1);

  logic [LANE_W-1:0] lane;

  // High while the next byte to arrive fills the final lane of the word.
  assign last_lane = (lane == LANE_TOP);

  // Lane counter and word register; clear wins over a new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      lane <= '0;
    end else if (clear) begin
      word <= '0;
      lane <= '0;
    end else if (byte_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (lane == LANE_W'(i)) word[8*i +: 8] <= byte_data;
      end
      lane <= lane + LANE_ONE;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory one byte at a time, then
// releases the core from reset. Overflowing memory parks the loader in an
// error state with the core held in reset until a start pulse reloads.
//
// Handshake: a byte transfers on a rising edge where s_valid and s_ready are
// both 1. While s_valid=1 and s_ready=0 upstream holds s_data/s_last stable;
// s_data and s_last are don't-care whenever s_valid=0.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int I_ADDR_BITS      = I_ADDR_BITS_DEF,
  parameter int INSTRUCTION_SIZE = INSTRUCTION_SIZE_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  input  logic [7:0]                  s_data,
  input  logic                        s_last,
  output logic                        s_ready,
  input  logic                        start,
  output logic                        im_we,
  output logic [I_ADDR_BITS-1:0]      im_addr,
  output logic [INSTRUCTION_SIZE-1:0] im_wdata,
  output logic                        cpu_rst_n,
  output logic                        done,
  output logic                        err,
  output logic [I_ADDR_BITS:0]        word_count,
  output logic [1:0]                  state_dbg
);

  localparam logic [I_ADDR_BITS-1:0] PTR_MAX = '1;
  localparam logic [I_ADDR_BITS-1:0] PTR_ONE = I_ADDR_BITS'(1);
  localparam logic [I_ADDR_BITS:0]   WC_ONE  = (I_ADDR_BITS+1)'(1);

  ld_state_t              state;
  logic [I_ADDR_BITS-1:0] ptr;
  logic                   last_seen;
  logic                   accept;
  logic                   final_byte;
  logic                   restart;
  logic                   pk_clear;
  logic                   last_lane;

  // s_ready is only ever high in LOAD, so accept implies LOAD.
  assign accept     = s_valid & s_ready;
  assign final_byte = accept & (s_last | last_lane);
  assign restart    = start & ((state == ST_RUN) | (state == ST_ERR));
  assign pk_clear   = (state == ST_WRITE) | restart;

  assign im_addr   = ptr;
  assign state_dbg = state;

  imem_word_packer #(
    .INSTRUCTION_SIZE(INSTRUCTION_SIZE)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .byte_en   (accept),
    .byte_data (s_data),
    .word      (im_wdata),
    .last_lane (last_lane)
  );

  // Loader FSM with all control outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_LOAD;
      ptr        <= '0;
      word_count <= '0;
      last_seen  <= 1'b0;
      s_ready    <= 1'b1;
      im_we      <= 1'b0;
      cpu_rst_n  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (final_byte) begin
            state     <= ST_WRITE;
            s_ready   <= 1'b0;
            im_we     <= 1'b1;
            last_seen <= s_last;
          end
        end
        ST_WRITE: begin
          im_we      <= 1'b0;
          ptr        <= ptr + PTR_ONE;
          word_count <= word_count + WC_ONE;
          if (last_seen) begin
            state     <= ST_RUN;
            cpu_rst_n <= 1'b1;
            done      <= 1'b1;
          end else if (ptr == PTR_MAX) begin
            state <= ST_ERR;
            err   <= 1'b1;
          end else begin
            state   <= ST_LOAD;
            s_ready <= 1'b1;
          end
        end
        ST_RUN, ST_ERR: begin
          if (start) begin
            state      <= ST_LOAD;
            ptr        <= '0;
            word_count <= '0;
            last_seen  <= 1'b0;
            s_ready    <= 1'b1;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed table of small programs, multi-cycle
// sequences for reset mid-load and memory overflow, and random programs
// checked against a byte-stream packing model.
module tb_imem_loader;

  localparam int AW    = 6;
  localparam int IW    = 32;
  localparam int DEPTH = 64;
  localparam int TMO   = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_last;
  logic          s_ready;
  logic          start;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [IW-1:0] im_wdata;
  logic          cpu_rst_n;
  logic          done;
  logic          err;
  logic [AW:0]   word_count;
  logic [1:0]    state_dbg;

  imem_loader #(.I_ADDR_BITS(AW), .INSTRUCTION_SIZE(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .start      (start),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .done       (done),
    .err        (err),
    .word_count (word_count),
    .state_dbg  (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: expected {addr, data} of each memory write, in order.
  logic [AW+IW-1:0] exp_q[$];
  logic [AW+IW-1:0] mon_e;
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && im_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write", im_addr, im_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("write@%0d", mon_e[AW+IW-1:IW]), {im_addr, im_wdata}, mon_e);
      end
    end
  end

  // Reference model: byte i of the stream belongs to word i/4, lane i%4;
  // only the first DEPTH words fit in memory.
  task automatic expect_program(input logic [7:0] b[$]);
    int nw;
    logic [IW-1:0] w;
    nw = (b.size() + 3) / 4;
    if (nw > DEPTH) nw = DEPTH;
    for (int wi = 0; wi < nw; wi++) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        if (wi*4 + k < b.size()) w = w | (IW'(b[wi*4 + k]) << (8*k));
      end
      exp_q.push_back({AW'(wi), w});
    end
  endtask

  // Driver: idle gap cycles with junk on the data lines, then offer a byte
  // until the loader takes it. Returns at the accepting edge + 1.
  task automatic send_byte(input logic [7:0] d, input bit last, input int gap, input bit rnd_start);
    bit ok;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
      start   = rnd_start ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    start   = rnd_start ? 1'($urandom) : 1'b0;
    ok = 1'b0;
    for (int t = 0; t < TMO; t++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL handshake_timeout: byte 0x%02h not accepted in %0d cycles, expected acceptance", d, TMO);
    end
  endtask

  task automatic send_program(input logic [7:0] b[$], input bit with_last, input int max_gap, input bit fixed_gap, input bit rnd_start);
    int gap;
    foreach (b[i]) begin
      gap = fixed_gap ? max_gap : $urandom_range(0, max_gap);
      send_byte(b[i], with_last && (i == b.size() - 1), gap, rnd_start);
    end
  endtask

  // Called right after the final-byte edge: write strobe now, RUN next cycle.
  task automatic check_run(input string tag, input int exp_wc);
    check({tag, "_we"}, im_we, 1);
    @(posedge clk); #1;
    check({tag, "_done"}, done, 1);
    check({tag, "_cpu_rst_n"}, cpu_rst_n, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_wc"}, word_count, exp_wc);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_we_off"}, im_we, 0);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic do_restart(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_wc"}, word_count, 0);
    check({tag, "_s_ready"}, s_ready, 1);
    check({tag, "_addr"}, im_addr, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, s_ready, 1);
    check({tag, "_we"}, im_we, 0);
    check({tag, "_addr"}, im_addr, 0);
    check({tag, "_wdata"}, im_wdata, 0);
    check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_wc"}, word_count, 0);
  endtask

  // Directed programs: bytes packed LE into a 64-bit field, plus expected words.
  typedef struct {
    logic [63:0] bytes;
    int          n;
    int          gap;
    int          exp_wc;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
  } vec_t;

  vec_t vecs[5];

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] b[$];
    int len;

    vecs[0] = '{64'h0000_0000_0050_0013, 4, 0, 1, 32'h0050_0013, 32'h0};
    vecs[1] = '{64'h0807_0605_0403_0201, 8, 1, 2, 32'h0403_0201, 32'h0807_0605};
    vecs[2] = '{64'h0000_2211_DDCC_BBAA, 6, 0, 2, 32'hDDCC_BBAA, 32'h0000_2211};
    vecs[3] = '{64'h0000_0000_0000_007F, 1, 2, 1, 32'h0000_007F, 32'h0};
    vecs[4] = '{64'h0000_0050_4030_2010, 5, 0, 2, 32'h4030_2010, 32'h0000_0050};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      if (i > 0) do_restart($sformatf("restart%0d", i));
      b = {};
      for (int k = 0; k < vecs[i].n; k++) b.push_back(vecs[i].bytes[8*k +: 8]);
      exp_q.push_back({AW'(0), vecs[i].exp_w0});
      if (vecs[i].exp_wc == 2) exp_q.push_back({AW'(1), vecs[i].exp_w1});
      send_program(b, 1'b1, vecs[i].gap, 1'b1, 1'b0);
      check_run($sformatf("vec%0d", i), vecs[i].exp_wc);
    end

    // Reset after two bytes of word 0: partial word dropped, no write.
    do_restart("pre_midrst");
    b = {8'hAA, 8'hBB};
    send_program(b, 1'b0, 0, 1'b1, 1'b0);
    rst = 1'b1;
    #2;
    check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    b = {8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back({AW'(0), 32'h4433_2211});
    send_program(b, 1'b1, 0, 1'b1, 1'b0);
    check_run("after_midrst", 1);

    // Overflow: 64 full words with no s_last, then a 65th word is refused.
    do_restart("pre_ovf");
    b = {};
    for (int k = 0; k < DEPTH*4; k++) b.push_back(8'($urandom));
    expect_program(b);
    send_program(b, 1'b0, 1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("ovf_err", err, 1);
    check("ovf_cpu_rst_n", cpu_rst_n, 0);
    check("ovf_s_ready", s_ready, 0);
    check("ovf_done", done, 0);
    check("ovf_wc", word_count, DEPTH);
    check("ovf_pending", exp_q.size(), 0);
    s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("ovf_hold_s_ready", s_ready, 0);
    check("ovf_hold_err", err, 1);
    s_valid = 1'b0; s_last = 1'b0;
    do_restart("ovf_restart");

    // Random programs with gaps and stray start pulses during the load.
    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(1, 48);
      b = {};
      for (int k = 0; k < len; k++) b.push_back(8'($urandom));
      expect_program(b);
      send_program(b, 1'b1, 3, 1'b0, 1'b1);
      check_run($sformatf("rnd%0d", r), (len + 3) / 4);
      do_restart($sformatf("rnd%0d_restart", r));
    end

    repeat (3) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
